vram_arbiter: RTL and testbench

- Shares the single-port 16 KB video RAM between the video adapter's fetch engine (bitmap/attribute reads) and the Z80 CPU (reads and writes).
- Sits between the CPU bus decoder (VRAM window already decoded, 14-bit offset) and the synchronous block RAM.
- The video port has priority, with a bounded-starvation guarantee for the CPU. CPU stalls are driven onto the Z80 WAIT line.

---
 rtl/vram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - Video/CPU arbiter for the shared single-port 16 KB VRAM.
// Optional one-entry posted CPU write buffer enabled by defining VRAM_POSTED_WR_EN.
module vram_arbiter #(
    parameter int MAX_VID_BURST = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait_n,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        VID_A,
        VID_D,
        CPU_A,
        CPU_D,
        CPU_W,
        DONE_V,
        DONE_C
    } state_t;

    localparam logic [3:0] BURST = 4'(MAX_VID_BURST);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       cpu_pending;
    logic       vid_win;
    logic       rd_win;
    logic       wr_win;
    logic       drain_win;

`ifdef VRAM_POSTED_WR_EN
    logic        buf_valid;
    logic [13:0] buf_addr;
    logic [7:0]  buf_data;
    logic        post_accept;

    // A full buffer competes for the RAM exactly like a waiting CPU request.
    assign cpu_pending = cpu_req | buf_valid;
    assign post_accept = cpu_req & cpu_we & ~buf_valid & ~cpu_ack;
`else
    assign cpu_pending = cpu_req;
`endif

    assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

    always_comb begin
        state_nxt = state;
        vid_win   = 1'b0;
        rd_win    = 1'b0;
        wr_win    = 1'b0;
        drain_win = 1'b0;
        case (state)
            IDLE: begin
                if (vid_req && (!cpu_pending || starve_cnt < BURST)) begin
                    vid_win   = 1'b1;
                    state_nxt = VID_A;
                end
`ifdef VRAM_POSTED_WR_EN
                else if (buf_valid) begin
                    drain_win = 1'b1;
                    state_nxt = CPU_W;
                end else if (cpu_req && !cpu_we) begin
                    rd_win    = 1'b1;
                    state_nxt = CPU_A;
                end
`else
                else if (cpu_req) begin
                    if (cpu_we) begin
                        wr_win    = 1'b1;
                        state_nxt = CPU_W;
                    end else begin
                        rd_win    = 1'b1;
                        state_nxt = CPU_A;
                    end
                end
`endif
            end
            VID_A:  state_nxt = VID_D;
            VID_D:  state_nxt = DONE_V;
            CPU_A:  state_nxt = CPU_D;
            CPU_D:  state_nxt = DONE_C;
`ifdef VRAM_POSTED_WR_EN
            CPU_W:  state_nxt = IDLE;
`else
            CPU_W:  state_nxt = DONE_C;
`endif
            DONE_V: state_nxt = IDLE;
            DONE_C: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only IDLE arbitrates, so the counter is only touched there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!cpu_pending || rd_win || wr_win || drain_win) begin
                starve_cnt <= 4'd0;
            end else if (vid_win && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= 14'd0;
            mem_wdata <= 8'd0;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= wr_win | drain_win;
            if (vid_win) begin
                mem_addr <= vid_addr;
            end else if (rd_win) begin
                mem_addr <= cpu_addr;
            end else if (wr_win) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end
`ifdef VRAM_POSTED_WR_EN
            else if (drain_win) begin
                mem_addr  <= buf_addr;
                mem_wdata <= buf_data;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vid_data  <= 8'd0;
            cpu_rdata <= 8'd0;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
        end else begin
            if (state == VID_D) begin
                vid_data <= mem_rdata;
            end
            if (state == CPU_D) begin
                cpu_rdata <= mem_rdata;
            end
            vid_ack <= (state_nxt == DONE_V);
`ifdef VRAM_POSTED_WR_EN
            cpu_ack <= (state_nxt == DONE_C) | post_accept;
`else
            cpu_ack <= (state_nxt == DONE_C);
`endif
        end
    end

`ifdef VRAM_POSTED_WR_EN
    // Fill and drain are mutually exclusive: fill needs an empty buffer, drain a full one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= 14'd0;
            buf_data  <= 8'd0;
        end else if (post_accept) begin
            buf_valid <= 1'b1;
            buf_addr  <= cpu_addr;
            buf_data  <= cpu_wdata;
        end else if (drain_win) begin
            buf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - Scoreboard testbench for vram_arbiter with a synchronous RAM model.
`timescale 1ns/1ps
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [13:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_ack;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait_n;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int we_count = 0;

    logic [7:0]  ram [0:16383];
    logic [7:0]  ref_mem [0:16383];
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    logic [7:0] vid_exp [$];
    logic [7:0] cpu_exp [$];
    logic       order_exp [$];

    vram_arbiter #(.MAX_VID_BURST(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_ack    (vid_ack),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_wait_n (cpu_wait_n),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clock) if (mem_we) we_count <= we_count + 1;

    task automatic preload(input logic [13:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    task automatic wait_ack(input bit cpu_side, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if ((cpu_side ? cpu_ack : vid_ack) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_req = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if ({mem_addr, mem_wdata, mem_we, vid_data, vid_ack, cpu_rdata, cpu_ack} !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0",
                     {mem_addr, mem_wdata, mem_we, vid_data, vid_ack, cpu_rdata, cpu_ack});
        end
        vectors++;
        if (cpu_wait_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wait_req: got %b required 0", cpu_wait_n);
        end
        cpu_req = 1'b0; #1;
        vectors++;
        if (cpu_wait_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wait_idle: got %b required 1", cpu_wait_n);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_video();
        int n, at;
        logic [7:0] e;
        preload(14'h1800, 8'hA5);
        preload(14'h1801, 8'h5A);
        @(posedge clock); #1;
        n = cyc; vid_addr = 14'h1800; vid_req = 1'b1;
        vid_exp.push_back(ref_mem[14'h1800]);
        @(negedge clock); @(negedge clock);
        vectors++;
        if (mem_addr !== 14'h1800) begin
            miscompares++;
            $display("FAIL vid_mem_addr: got %h required 1800", mem_addr);
        end
        wait_ack(1'b0, 10, at);
        e = vid_exp.pop_front();
        vectors++;
        if (at !== n + 3 || vid_data !== e) begin
            miscompares++;
            $display("FAIL vid_read: ack cycle %0d data %h required cycle %0d data %h", at, vid_data, n + 3, e);
        end
        @(posedge clock); #1;
        vid_addr = 14'h1801;
        vid_exp.push_back(ref_mem[14'h1801]);
        @(negedge clock); @(negedge clock);
        vectors++;
        if (mem_addr !== 14'h1801) begin
            miscompares++;
            $display("FAIL vid_regrant_addr: got %h required 1801", mem_addr);
        end
        wait_ack(1'b0, 10, at);
        e = vid_exp.pop_front();
        vectors++;
        if (at !== n + 7 || vid_data !== e) begin
            miscompares++;
            $display("FAIL vid_back_to_back: ack cycle %0d data %h required cycle %0d data %h", at, vid_data, n + 7, e);
        end
        @(posedge clock); #1;
        vid_req = 1'b0;
    endtask

    task automatic test_cpu_read();
        int n, at;
        logic [7:0] e;
        preload(14'h0123, 8'h3C);
        @(posedge clock); #1;
        n = cyc; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        cpu_exp.push_back(ref_mem[14'h0123]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            vectors++;
            if (cpu_wait_n !== 1'b0) begin
                miscompares++;
                $display("FAIL cpu_rd_wait_n%0d: got %b required 0", k, cpu_wait_n);
            end
        end
        wait_ack(1'b1, 10, at);
        e = cpu_exp.pop_front();
        vectors++;
        if (at !== n + 3 || cpu_rdata !== e || cpu_wait_n !== 1'b1) begin
            miscompares++;
            $display("FAIL cpu_read: ack cycle %0d data %h wait_n %b required cycle %0d data %h wait_n 1",
                     at, cpu_rdata, cpu_wait_n, n + 3, e);
        end
        @(posedge clock); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_cpu_write();
        int n, at, we0, lat;
        logic [7:0] e;
`ifdef VRAM_POSTED_WR_EN
        lat = 1;
`else
        lat = 2;
`endif
        @(posedge clock); #1;
        n = cyc; we0 = we_count;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0005; cpu_wdata = 8'h7E;
        ref_mem[14'h0005] = 8'h7E;
        wait_ack(1'b1, 10, at);
        vectors++;
        if (at !== n + lat) begin
            miscompares++;
            $display("FAIL cpu_write_ack: ack cycle %0d required %0d", at, n + lat);
        end
        @(posedge clock); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        vectors++;
        if (we_count - we0 !== 1) begin
            miscompares++;
            $display("FAIL cpu_write_we_len: mem_we cycles %0d required 1", we_count - we0);
        end
        n = cyc; cpu_req = 1'b1; cpu_addr = 14'h0005;
        cpu_exp.push_back(ref_mem[14'h0005]);
        wait_ack(1'b1, 10, at);
        e = cpu_exp.pop_front();
        vectors++;
        if (at !== n + 3 || cpu_rdata !== e) begin
            miscompares++;
            $display("FAIL cpu_readback: ack cycle %0d data %h required cycle %0d data %h", at, cpu_rdata, n + 3, e);
        end
        @(posedge clock); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_contention();
        int run, max_run;
        logic got;
        run = 0; max_run = 0;
        order_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(posedge clock); #1;
        vid_req = 1'b1; vid_addr = 14'h1800;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        for (int i = 0; i < 80 && order_exp.size() != 0; i++) begin
            @(negedge clock);
            if (cpu_wait_n === 1'b0) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (vid_ack === 1'b1 || cpu_ack === 1'b1) begin
                got = cpu_ack;
                vectors++;
                if (got !== order_exp[0] ||
                    (got ? cpu_rdata !== ref_mem[14'h0123] : vid_data !== ref_mem[14'h1800])) begin
                    miscompares++;
                    $display("FAIL contention_order: grant %0d was cpu=%b data %h required cpu=%b",
                             6 - order_exp.size(), got, got ? cpu_rdata : vid_data, order_exp[0]);
                end
                void'(order_exp.pop_front());
            end
        end
        vectors++;
        if (order_exp.size() != 0) begin
            miscompares++;
            $display("FAIL contention_timeout: %0d grants missing required 0", order_exp.size());
        end
        vectors++;
        if (max_run > 12) begin
            miscompares++;
            $display("FAIL contention_starve: cpu wait %0d clocks required <= 12", max_run);
        end
        @(posedge clock); #1;
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        int n2, at;
        logic [7:0] e;
        @(posedge clock); #1;
        vid_req = 1'b1; vid_addr = 14'h1800;
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b0; #1;
        vectors++;
        if ({mem_addr, mem_wdata, mem_we, vid_data, vid_ack, cpu_rdata, cpu_ack} !== 41'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {mem_addr, mem_wdata, mem_we, vid_data, vid_ack, cpu_rdata, cpu_ack});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        n2 = cyc;
        vid_exp.push_back(ref_mem[14'h1800]);
        wait_ack(1'b0, 10, at);
        e = vid_exp.pop_front();
        vectors++;
        if (at !== n2 + 3 || vid_data !== e) begin
            miscompares++;
            $display("FAIL mid_reset_retry: ack cycle %0d data %h required cycle %0d data %h", at, vid_data, n2 + 3, e);
        end
        @(posedge clock); #1;
        vid_req = 1'b0;
    endtask

`ifdef VRAM_POSTED_WR_EN
    task automatic test_posted();
        int n, at;
        logic first_cpu, seen;
        logic [7:0] e;
        seen = 1'b0; first_cpu = 1'b0;
        @(posedge clock); #1;
        n = cyc;
        vid_req = 1'b1; vid_addr = 14'h1800;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'h11;
        ref_mem[14'h0010] = 8'h11;
        wait_ack(1'b1, 10, at);
        vectors++;
        if (at !== n + 1) begin
            miscompares++;
            $display("FAIL posted_ack: ack cycle %0d required %0d", at, n + 1);
        end
        @(posedge clock); #1;
        cpu_we = 1'b0;
        cpu_exp.push_back(ref_mem[14'h0010]);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!seen && (vid_ack === 1'b1 || cpu_ack === 1'b1)) begin
                seen = 1'b1; first_cpu = cpu_ack;
            end
            if (cpu_ack === 1'b1) begin
                at = cyc;
                break;
            end
        end
        e = cpu_exp.pop_front();
        vectors++;
        if (at < 0 || cpu_rdata !== e) begin
            miscompares++;
            $display("FAIL posted_raw: ack cycle %0d data %h required data %h", at, cpu_rdata, e);
        end
        vectors++;
        if (first_cpu !== 1'b0) begin
            miscompares++;
            $display("FAIL posted_vid_first: first ack cpu=%b required 0", first_cpu);
        end
        @(posedge clock); #1;
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (6) @(posedge clock);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_video();
        test_cpu_read();
        test_cpu_write();
        test_contention();
        test_reset_mid();
`ifdef VRAM_POSTED_WR_EN
        test_posted();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
